// File: rtl/bcd_scan_if.sv
// bcd_scan_if: counter-word inputs and display-pin outputs of the scan controller
interface bcd_scan_if;
  logic [8:0] word_lo;
  logic [8:0] word_hi;
  logic       enable;
  logic [3:0] brightness;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_start;
  logic       fmt_err;
  modport master (output word_lo, word_hi, enable, brightness, input seg, an, frame_start, fmt_err);
  modport slave (input word_lo, word_hi, enable, brightness, output seg, an, frame_start, fmt_err);
endinterface

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: four-digit 7-segment scanner with dead-time, PWM, leading-zero blanking and frame-atomic commit
module bcd_scan_ctrl #(
  parameter int F_CLK_HZ       = 25_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_CYCLES   = 64,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  bcd_scan_if.slave  bus
);
  localparam int SLOT_TKS = F_CLK_HZ / SCAN_HZ;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [15:0][6:0] SEG_LUT = {
    {6{7'b1000000}},
    7'b1101111, 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101,
    7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };
  typedef enum logic {BLANK, ON} state_t;
  state_t      state_q, state_d;
  logic [31:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  lo_q, lo_d, hi_q, hi_d;
  logic [15:0] disp_q, disp_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        fs_q, fs_d, err_q, err_d;
  logic        wrap, commit, lz;
  logic [3:0]  digit, pwm;
  always_comb begin
    wrap       = slot_cnt_q == 32'(SLOT_TKS - 1);
    commit     = wrap && idx_q == 2'd3;
    slot_cnt_d = wrap ? '0 : slot_cnt_q + 32'd1;
    idx_d      = wrap ? idx_q + 2'd1 : idx_q;
    state_d    = (slot_cnt_d < 32'(BLANK_CYCLES)) ? BLANK : ON;
    lo_d       = bus.word_lo[8] ? lo_q : bus.word_lo[7:0];
    hi_d       = bus.word_hi[8] ? bus.word_hi[7:0] : hi_q;
    err_d      = err_q | bus.word_lo[8] | ~bus.word_hi[8];
    // commit reads the pre-edge shadow, so a same-edge capture waits a frame
    disp_d     = commit ? {hi_q, lo_q} : disp_q;
    fs_d       = commit;
    digit      = disp_q[{idx_q, 2'b00} +: 4];
    pwm        = slot_cnt_q[3:0] - 4'(BLANK_CYCLES);
    lz         = (LZ_BLANK != 0) && (idx_q == 2'd3 ? disp_q[15:12] == 4'd0 :
                                     idx_q == 2'd2 ? disp_q[15:8] == 8'd0 :
                                     idx_q == 2'd1 ? disp_q[15:4] == 12'd0 : 1'b0);
    seg_d      = SEG_LUT[digit] ^ SEG_OFF;
    an_d       = AN_OFF ^ ((state_q == ON && bus.enable && pwm <= bus.brightness && !lz) ?
                           4'b0001 << idx_q : 4'b0000);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= BLANK;
      slot_cnt_q <= '0;
      idx_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      disp_q     <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
      fs_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      disp_q     <= disp_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
      err_q      <= err_d;
    end
  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;
  assign bus.fmt_err     = err_q;
endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb_bcd_scan_ctrl: directed frames checked by a per-frame scoreboard monitor
module tb_bcd_scan_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  bcd_scan_if bus ();
  bcd_scan_ctrl #(.F_CLK_HZ(1000), .SCAN_HZ(50), .BLANK_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0][4:0] on;
    logic [3:0][6:0] sg;
  } exp_t;
  exp_t exq[$];
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                         S4 = 7'b0011001, S5 = 7'b0010010, S8 = 7'b0000000, S9 = 7'b0010000,
                         SD = 7'b0111111, SX = 7'b1111111;
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic expect_frame(input int m, input int c, input int d, input int u,
                              input logic [6:0] sm, input logic [6:0] sc,
                              input logic [6:0] sd, input logic [6:0] su);
    exp_t e;
    e.on = {5'(m), 5'(c), 5'(d), 5'(u)};
    e.sg = {sm, sc, sd, su};
    exq.push_back(e);
  endtask
  task automatic measure(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_start && n < 200);
    #1;
  endtask
  task automatic wait_frame();
    int n;
    measure(n);
    check("frame_start_timeout", int'(n < 200), 1);
  endtask
  initial begin : monitor
    logic [3:0][4:0] on_c;
    logic [3:0][6:0] sg_c;
    int k, stray;
    bit col;
    exp_t e;
    col = 0;
    k = 0;
    stray = 0;
    on_c = '0;
    sg_c = '0;
    forever begin
      @(negedge clk);
      if (col) begin
        k++;
        for (int d = 0; d < 4; d++)
          if (!bus.an[d]) begin
            on_c[d] = on_c[d] + 5'd1;
            sg_c[d] = bus.seg;
            if (d != (k - 1) / 20 || (k - 1) % 20 < 4) stray++;
          end
        if (k == 80) begin
          col = 0;
          if (exq.size() > 0) begin
            e = exq.pop_front();
            for (int d = 0; d < 4; d++) begin
              check($sformatf("on_cycles_digit%0d", d), int'(on_c[d]), int'(e.on[d]));
              if (e.on[d] != 0) check($sformatf("seg_digit%0d", d), int'(sg_c[d]), int'(e.sg[d]));
            end
            check("stray_anode", stray, 0);
          end
        end
      end
      if (bus.frame_start) begin
        col = 1;
        k = 0;
        stray = 0;
        on_c = '0;
        sg_c = '0;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    bus.word_lo = 9'h000;
    bus.word_hi = 9'h100;
    bus.enable = 1'b1;
    bus.brightness = 4'd15;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    bus.word_lo = 9'h101;
    repeat (2) @(negedge clk);
    check("fmt_err_set", bus.fmt_err, 1);
    bus.word_lo = 9'h000;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset_an", bus.an, 4'hF);
    check("reset_seg", bus.seg, 7'h7F);
    check("reset_fmt_err", bus.fmt_err, 0);
    check("reset_frame_start", bus.frame_start, 0);
    @(negedge clk);
    reset_n = 1'b1;
    measure(n);
    check("first_frame_start", n, 80);
    measure(n);
    check("frame_period", n, 80);
    check("fmt_err_after_reset", bus.fmt_err, 0);
    bus.word_lo = 9'h034;
    bus.word_hi = 9'h112;
    wait_frame();
    expect_frame(16, 16, 16, 16, S1, S2, S3, S4);
    wait_frame();
    bus.word_lo = 9'h005;
    bus.word_hi = 9'h100;
    wait_frame();
    expect_frame(0, 0, 0, 16, SX, SX, SX, S5);
    wait_frame();
    bus.word_lo = 9'h000;
    wait_frame();
    expect_frame(0, 0, 0, 16, SX, SX, SX, S0);
    wait_frame();
    bus.word_lo = 9'h034;
    bus.word_hi = 9'h112;
    bus.brightness = 4'd0;
    wait_frame();
    expect_frame(1, 1, 1, 1, S1, S2, S3, S4);
    wait_frame();
    bus.brightness = 4'd15;
    repeat (10) @(negedge clk);
    check("an_u_active", bus.an, 4'b1110);
    bus.enable = 1'b0;
    @(negedge clk);
    check("an_disable", bus.an, 4'hF);
    wait_frame();
    expect_frame(0, 0, 0, 0, SX, SX, SX, SX);
    wait_frame();
    bus.enable = 1'b1;
    bus.word_lo = 9'h101;
    bus.word_hi = 9'h1A0;
    repeat (2) @(negedge clk);
    check("fmt_err_bad_tag", bus.fmt_err, 1);
    wait_frame();
    expect_frame(16, 16, 16, 16, SD, S0, S3, S4);
    bus.word_lo = 9'h034;
    wait_frame();
    check("fmt_err_sticky", bus.fmt_err, 1);
    bus.word_hi = 9'h112;
    wait_frame();
    repeat (30) @(negedge clk);
    bus.word_lo = 9'h098;
    expect_frame(16, 16, 16, 16, S1, S2, S3, S4);
    wait_frame();
    expect_frame(16, 16, 16, 16, S1, S2, S9, S8);
    wait_frame();
    #2;
    check("scoreboard_drained", exq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
